// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl_if
//  Description : Bus bundle between the fetch sequencer, the instruction
//                ROM, the redirect source and the decode stage.
//  Signals     : rom_addr       - ROM address (fetch PC)
//                rom_instr      - ROM read data, one cycle after the address
//                redirect_valid - one-cycle restart request
//                redirect_pc    - restart target (byte address)
//                out_valid      - head instruction available to decode
//                out_ready      - decode accepts the head this cycle
//                out_instr      - head instruction word
//                out_pc         - PC of the head instruction
//  Modports    : master - the fetch sequencer
//                slave  - the environment (ROM, redirect source, decode)
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 48
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output rom_addr,
        output out_valid,
        output out_instr,
        output out_pc,
        input  rom_instr,
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready
    );

    modport slave (
        input  rom_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output rom_instr,
        output redirect_valid,
        output redirect_pc,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl
//  Description : Fetch sequencer for the instruction ROM. Owns the fetch PC,
//                tracks the ROM's one-cycle read latency, buffers returned
//                words in a 2-entry FIFO and hands {instr, pc} to decode over
//                a valid/ready handshake (up to one instruction per cycle).
//                A redirect flushes buffered and in-flight fetches and
//                restarts fetching at the redirect target.
//  Ports       : CLK   - clock, all state updates on the rising edge
//                Reset - asynchronous, active-high reset
//                bus   - instr_fetch_ctrl_if.master (ROM, redirect, decode)
//  Parameters  : ADDR_W   - PC / ROM address width
//                INSTR_W  - instruction word width
//                RESET_PC - PC loaded on reset
//                PC_STEP  - byte increment per instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 48,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  wire logic           CLK,
    input  wire logic           Reset,
    instr_fetch_ctrl_if.master  bus
);

    localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(PC_STEP);

    // Fetch PC and the single outstanding ROM request
    logic [ADDR_W-1:0]  r_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;

    // 2-entry FIFO of returned words, addressed by 1-bit pointers
    logic [INSTR_W-1:0] r_fifo_instr [2];
    logic [ADDR_W-1:0]  r_fifo_pc    [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [2:0]         w_occupancy;

    // Handshake with decode
    assign w_pop = bus.out_valid & bus.out_ready;

    // Slots that will be committed after this edge: buffered words plus the
    // word coming back from the ROM, minus the one leaving to decode. A new
    // request is only launched when its response is guaranteed a slot, which
    // is what keeps the FIFO from ever overflowing.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (w_occupancy < 3'd2) & ~bus.redirect_valid;

    // A redirect discards the word currently returning from the ROM
    assign w_push = r_inflight & ~bus.redirect_valid;

    // ------------------------------------------------------------------------
    // PC and in-flight tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            r_pc          <= bus.redirect_pc;
            r_inflight    <= 1'b0;
        end else if (w_issue) begin
            r_pc          <= r_pc + C_PC_STEP;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Flush; a pop in this same cycle has already been handed over
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= bus.rom_instr;
                r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.rom_addr  = r_pc;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_instr = r_fifo_instr[r_rd_ptr];
    assign bus.out_pc    = r_fifo_pc[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_ctrl
//  Description : Directed self-checking bench for instr_fetch_ctrl. A main
//                instance (RESET_PC = 0) exercises streaming, backpressure,
//                redirects and asynchronous reset; a second instance with
//                RESET_PC = 32'hFFFF_FFFC exercises PC wrap-around.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 48;

    logic CLK;
    logic Reset;

    int tests_run;
    int tests_failed;

    instr_fetch_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus   ();
    instr_fetch_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_w ();

    instr_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    instr_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (32'hFFFF_FFFC),
        .PC_STEP  (4)
    ) dut_wrap (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus_w)
    );

    // Clock: rising edges at 5, 15, 25 ...; sampling happens on falling edges
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ROM contents: a distinct word per address
    function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {a[15:0] ^ 16'hC3A5, a ^ 32'h1234_5678};
    endfunction

    // Synchronous-read ROM models, one-cycle latency
    always @(posedge CLK) bus.rom_instr   <= rom_word(bus.rom_addr);
    always @(posedge CLK) bus_w.rom_instr <= rom_word(bus_w.rom_addr);

    // Assert reset for two cycles; returns at the falling edge where reset
    // deasserts (cycle 0 after release).
    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        tests_run++;
        if (bus.rom_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rom_addr: got %h expected 00000000", bus.rom_addr);
        end
        tests_run++;
        if (bus.out_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_out_pc: got %h expected 00000000", bus.out_pc);
        end
        tests_run++;
        if (bus.out_instr !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_out_instr: got %h expected 0", bus.out_instr);
        end
        tests_run++;
        if (bus_w.rom_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL reset_wrap_rom_addr: got %h expected fffffffc", bus_w.rom_addr);
        end
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Checks cycles 0..5 after reset release with out_ready held high.
    task automatic check_stream(input string tag);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL %s_cycle0: got valid=%b addr=%h expected valid=0 addr=00000000",
                     tag, bus.out_valid, bus.rom_addr);
        end
        @(negedge CLK);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL %s_cycle1: got valid=%b addr=%h expected valid=0 addr=00000004",
                     tag, bus.out_valid, bus.rom_addr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4) ||
                bus.out_instr !== rom_word(32'(i * 4))) begin
                tests_failed++;
                $display("FAIL %s_word%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                         tag, i, bus.out_valid, bus.out_pc, bus.out_instr,
                         32'(i * 4), rom_word(32'(i * 4)));
            end
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        do_reset();
        check_stream("stream");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        do_reset();
        repeat (2) @(negedge CLK);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.rom_addr !== 32'h8) begin
                tests_failed++;
                $display("FAIL bp_stall%0d: got valid=%b pc=%h addr=%h expected valid=1 pc=00000000 addr=00000008",
                         k, bus.out_valid, bus.out_pc, bus.rom_addr);
            end
            @(negedge CLK);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4) ||
                bus.out_instr !== rom_word(32'(i * 4))) begin
                tests_failed++;
                $display("FAIL bp_drain%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                         i, bus.out_valid, bus.out_pc, bus.out_instr,
                         32'(i * 4), rom_word(32'(i * 4)));
            end
            @(negedge CLK);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_redirect();
        bus.out_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge CLK);
        // Steady streaming: head pc=4 is popped in the redirect cycle
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge CLK);
        bus.redirect_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h40) begin
            tests_failed++;
            $display("FAIL redir_c1: got valid=%b addr=%h expected valid=0 addr=00000040",
                     bus.out_valid, bus.rom_addr);
        end
        @(negedge CLK);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_c2: got valid=%b expected 0", bus.out_valid);
        end
        @(negedge CLK);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== rom_word(32'h40)) begin
            tests_failed++;
            $display("FAIL redir_c3: got valid=%b pc=%h instr=%h expected valid=1 pc=00000040 instr=%h",
                     bus.out_valid, bus.out_pc, bus.out_instr, rom_word(32'h40));
        end
        @(negedge CLK);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h44) begin
            tests_failed++;
            $display("FAIL redir_c4: got valid=%b pc=%h expected valid=1 pc=00000044",
                     bus.out_valid, bus.out_pc);
        end
        // Fill the FIFO, then redirect while stalled
        bus.out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h60;
        @(negedge CLK);
        bus.redirect_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h60) begin
            tests_failed++;
            $display("FAIL redir_full_c1: got valid=%b addr=%h expected valid=0 addr=00000060",
                     bus.out_valid, bus.rom_addr);
        end
        repeat (2) @(negedge CLK);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h60 || bus.out_instr !== rom_word(32'h60)) begin
            tests_failed++;
            $display("FAIL redir_full_c3: got valid=%b pc=%h instr=%h expected valid=1 pc=00000060 instr=%h",
                     bus.out_valid, bus.out_pc, bus.out_instr, rom_word(32'h60));
        end
        bus.out_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge CLK);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        @(negedge CLK);
        bus.redirect_pc    = 32'h80;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_c1: got valid=%b pc=%h expected valid=0", bus.out_valid, bus.out_pc);
        end
        @(negedge CLK);
        bus.redirect_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h80) begin
            tests_failed++;
            $display("FAIL b2b_c2: got valid=%b addr=%h expected valid=0 addr=00000080",
                     bus.out_valid, bus.rom_addr);
        end
        @(negedge CLK);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_c3: got valid=%b pc=%h expected valid=0", bus.out_valid, bus.out_pc);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(32'h80 + i * 4) ||
                bus.out_instr !== rom_word(32'(32'h80 + i * 4))) begin
                tests_failed++;
                $display("FAIL b2b_word%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                         i, bus.out_valid, bus.out_pc, bus.out_instr,
                         32'(32'h80 + i * 4), rom_word(32'(32'h80 + i * 4)));
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_async_reset();
        bus.out_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b addr=%h expected valid=0 addr=00000000",
                     bus.out_valid, bus.rom_addr);
        end
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        check_stream("restart");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFFC;
        exp_pc[1] = 32'h0000_0000;
        exp_pc[2] = 32'h0000_0004;
        do_reset();
        tests_run++;
        if (bus_w.rom_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_start_addr: got %h expected fffffffc", bus_w.rom_addr);
        end
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus_w.out_valid !== 1'b1 || bus_w.out_pc !== exp_pc[i] ||
                bus_w.out_instr !== rom_word(exp_pc[i])) begin
                tests_failed++;
                $display("FAIL wrap_word%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                         i, bus_w.out_valid, bus_w.out_pc, bus_w.out_instr,
                         exp_pc[i], rom_word(exp_pc[i]));
            end
            @(negedge CLK);
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        tests_run            = 0;
        tests_failed         = 0;
        Reset                = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus.out_ready        = 1'b0;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;
        bus_w.out_ready      = 1'b1;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        repeat (3) @(negedge CLK);

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_async_reset();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
